// File: rtl/uint_mod_reducer_pkg.sv
// Shared constants for the reduced-modulus datapath: modulus, accumulator widths and FSM encodings.
// Imported by uint_mod_reducer and cond_sub_step.
package PARAMS_BN254_d0;

    localparam int M_W = 16;

    typedef logic [M_W-1:0] uint_fp_t;

    localparam uint_fp_t M_tilde = 16'hFFF1;

    // Carry headroom added by the L3 stage on top of the 12*M_tilde accumulator.
    localparam int L3_CARRY      = 4;
    localparam int LEN_12M_TILDE = 26;

    localparam int SHIFT_MAX_DEF = L3_CARRY + 9;
    localparam int RED_STEPS     = SHIFT_MAX_DEF + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/uint_mod_reducer_cond_sub_step.sv
// One restoring-reduction step: tries r - (M_tilde << k) at width IN_W+1.
// A shifted modulus with bits above IN_W can never fit, so it forces a keep.
module cond_sub_step
    import PARAMS_BN254_d0::*;
#(
    parameter int IN_W      = LEN_12M_TILDE + L3_CARRY,
    parameter int SHIFT_MAX = SHIFT_MAX_DEF,
    parameter int KW        = 4
) (
    input  logic [IN_W-1:0] r,
    input  logic [KW-1:0]   k,
    output logic [IN_W-1:0] r_next,
    output logic            borrow
);

    localparam int WIDE_W = IN_W + SHIFT_MAX + M_W;

    logic [WIDE_W-1:0] m_shifted;
    logic [IN_W:0]     diff;
    logic              too_wide;

    always_comb begin
        m_shifted = WIDE_W'(M_tilde) << k;
        too_wide  = |m_shifted[WIDE_W-1:IN_W];
        diff      = {1'b0, r} - {1'b0, m_shifted[IN_W-1:0]};
        borrow    = too_wide | diff[IN_W];
        r_next    = borrow ? r : diff[IN_W-1:0];
    end

endmodule

// File: rtl/uint_mod_reducer.sv
// Iterative din mod M_tilde: SHIFT_MAX+1 conditional subtractions of M_tilde<<k, k descending.
// Define UINT_MOD_REDUCER_OVF_CHECK_EN to add the ovf range flag.
module uint_mod_reducer
    import PARAMS_BN254_d0::*;
#(
    parameter int SHIFT_MAX = L3_CARRY + 9,
    parameter int IN_W      = LEN_12M_TILDE + L3_CARRY
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             din,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$bits(uint_fp_t)-1:0] dout
`ifdef UINT_MOD_REDUCER_OVF_CHECK_EN
    ,
    output logic                        ovf
`endif
);

    localparam int KW   = (SHIFT_MAX < 1) ? 1 : $clog2(SHIFT_MAX + 1);
    localparam int FP_W = $bits(uint_fp_t);

    logic [1:0]      state_reg, state_next;
    logic [IN_W-1:0] r_reg, r_next;
    logic [KW-1:0]   k_reg, k_next;

    logic [IN_W-1:0] step_r;
    logic            step_borrow;

    cond_sub_step #(
        .IN_W      (IN_W),
        .SHIFT_MAX (SHIFT_MAX),
        .KW        (KW)
    ) u_step (
        .r      (r_reg),
        .k      (k_reg),
        .r_next (step_r),
        .borrow (step_borrow)
    );

    always_comb begin
        state_next = state_reg;
        r_next     = r_reg;
        k_next     = k_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    r_next     = din;
                    k_next     = KW'(SHIFT_MAX);
                    state_next = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                r_next = step_borrow ? r_reg : step_r;
                if (k_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    k_next = k_reg - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            r_reg     <= '0;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            r_reg     <= r_next;
            k_reg     <= k_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign dout      = r_reg[FP_W-1:0];

`ifdef UINT_MOD_REDUCER_OVF_CHECK_EN
    // Compare in a width wide enough that M_tilde<<(SHIFT_MAX+1) is never truncated.
    localparam int LIM_W = IN_W + SHIFT_MAX + M_W + 1;
    localparam logic [LIM_W-1:0] OVF_LIMIT = LIM_W'(M_tilde) << (SHIFT_MAX + 1);

    logic ovf_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && in_valid) begin
            ovf_reg <= (LIM_W'(din) >= OVF_LIMIT);
        end else if (state_reg == ST_DONE && out_ready) begin
            ovf_reg <= 1'b0;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_uint_mod_reducer.sv
// Randomized + directed bench for uint_mod_reducer against a plain x % M_tilde model.
// Define UINT_MOD_REDUCER_OVF_CHECK_EN to also check the ovf flag.
module tb_uint_mod_reducer;
    import PARAMS_BN254_d0::*;

    localparam int SHIFT_MAX = L3_CARRY + 9;
    localparam int IN_W      = LEN_12M_TILDE + L3_CARRY;
    localparam int FP_W      = $bits(uint_fp_t);
    localparam longint unsigned MOD   = longint'(M_tilde);
    localparam longint unsigned RANGE = MOD << (SHIFT_MAX + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] din;
    logic            out_valid;
    logic            out_ready;
    logic [FP_W-1:0] dout;
`ifdef UINT_MOD_REDUCER_OVF_CHECK_EN
    logic            ovf;
`endif

    uint_mod_reducer #(
        .SHIFT_MAX (SHIFT_MAX),
        .IN_W      (IN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
`ifdef UINT_MOD_REDUCER_OVF_CHECK_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    longint unsigned cyc_cnt = 0;
    longint unsigned prev_acc = 0;
    bit  prev_fast = 1'b0;
    int  last_wait = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned ref_mod(input longint unsigned x);
        return x % MOD;
    endfunction

    task automatic do_txn(input longint unsigned d, input int stall, input bit noise);
        int waited;
        int lat;
        longint unsigned acc;
        logic [FP_W-1:0] held;
        in_valid = 1'b1;
        din      = IN_W'(d);
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check_val("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid  = 1'b0;
            prev_fast = 1'b0;
            return;
        end
        last_wait = waited;
        @(posedge clk); #1;
        acc = cyc_cnt;
        if (noise) din = IN_W'($urandom);
        else       in_valid = 1'b0;
        if (prev_fast && waited == 0)
            check_val("throughput", 64'(acc - prev_acc), 64'(SHIFT_MAX + 3));
        lat = 1;
        while (!out_valid && lat < SHIFT_MAX + 20) begin
            @(posedge clk); #1;
            lat++;
            if (noise) din = IN_W'($urandom);
        end
        check_val("latency", 64'(lat), 64'(SHIFT_MAX + 2));
        if (d < RANGE)
            check_val("dout", 64'(dout), 64'(ref_mod(d)));
        check_val("in_ready_done", 64'(in_ready), 64'd0);
`ifdef UINT_MOD_REDUCER_OVF_CHECK_EN
        check_val("ovf", 64'(ovf), 64'(d >= RANGE));
`endif
        $display("txn din=0x%0h dout=0x%0h ref=0x%0h lat=%0d stall=%0d noise=%0d",
                 d, dout, ref_mod(d), lat, stall, noise);
        held = dout;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (noise) din = IN_W'($urandom);
            check_val("stall_dout", 64'(dout), 64'(held));
            check_val("stall_valid", 64'(out_valid), 64'd1);
            check_val("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_val("idle_after_hs", 64'(in_ready), 64'd1);
        check_val("valid_after_hs", 64'(out_valid), 64'd0);
        prev_acc  = acc;
        prev_fast = (stall == 0);
    endtask

    longint unsigned directed[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_dout", 64'(dout), 64'd0);
`ifdef UINT_MOD_REDUCER_OVF_CHECK_EN
        check_val("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;

        directed[0] = 0;
        directed[1] = MOD - 1;
        directed[2] = MOD;
        directed[3] = 5 * MOD + 3;
        directed[4] = (MOD << SHIFT_MAX) + 7;
        directed[5] = 2 * MOD;
        directed[6] = 100 * MOD;
        directed[7] = RANGE - 1;
        for (int i = 0; i < 8; i++) begin
            do_txn(directed[i], 0, 1'b0);
            if (i == 0) check_val("accept_after_reset", 64'(last_wait), 64'd0);
        end

        do_txn(7 * MOD + 12345, 10, 1'b1);

        // Abort an operation mid-REDUCE with a one-cycle reset.
        prev_fast = 1'b0;
        in_valid  = 1'b1;
        din       = IN_W'(3 * MOD + 2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("abort_in_ready", 64'(in_ready), 64'd1);
        check_val("abort_dout", 64'(dout), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < SHIFT_MAX + 6; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check_val("abort_no_valid", 64'(seen), 64'd0);
        do_txn(2 * MOD + 1, 0, 1'b0);

`ifdef UINT_MOD_REDUCER_OVF_CHECK_EN
        do_txn(RANGE, 0, 1'b0);
        do_txn(MOD + 9, 0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            longint unsigned d;
            if ($urandom_range(3, 0) == 0) d = longint'($urandom_range(32'(4 * MOD), 0));
            else                           d = longint'($urandom_range(32'(RANGE - 1), 0));
            do_txn(d, int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uint_mod_reducer.md
UINT_MOD_REDUCER -- requirements
Module: uint_mod_reducer

Interface
REQ-001 SHALL have parameter SHIFT_MAX, default L3_CARRY+9, the highest shift k of M_tilde<<k tried during reduction.
REQ-002 SHALL have parameter IN_W, default LEN_12M_TILDE+L3_CARRY, the width of din (matches the L3touint output).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset; synchronous and active-low.
REQ-005 Port in_valid, input, 1, din is valid.
REQ-006 Port in_ready, output, 1, block accepts din.
REQ-007 Port din, input, IN_W, unsigned integer to reduce.
REQ-008 Port out_valid, output, 1, dout is valid.
REQ-009 Port out_ready, input, 1, consumer accepts dout.
REQ-010 Port dout, output, $bits(uint_fp_t), din mod M_tilde.
REQ-011 Port ovf, output, 1, input exceeded the reducible range; exists only with the macro of REQ-030.

Function
REQ-012 SHALL implement an FSM with states IDLE, REDUCE and DONE.
REQ-013 IDLE: in_ready=1; on in_valid, SHALL latch din into the remainder register R, set k=SHIFT_MAX, and go to REDUCE.
REQ-014 REDUCE: once per cycle SHALL compute R-(M_tilde<<k); if non-negative, R takes the difference, else R is kept; then k decrements.
REQ-015 After the k=0 step SHALL go to DONE; REDUCE lasts exactly SHIFT_MAX+1 cycles.
REQ-016 DONE: out_valid=1 and dout=R[$bits(uint_fp_t)-1:0], held stable until out_ready.
REQ-017 On out_valid&&out_ready SHALL return to IDLE; the next din is accepted no earlier than the following cycle.
REQ-018 Latency, from the accept edge to the first cycle out_valid=1: SHIFT_MAX+2 cycles. Throughput: one result per SHIFT_MAX+3 cycles when out_ready is held at 1.
REQ-019 in_ready SHALL be 0 in REDUCE and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb R.
REQ-020 Subtraction SHALL be performed at width IN_W+1; the borrow bit decides the step outcome.
REQ-021 M_tilde<<k bits above IN_W SHALL be treated as exact; a shifted modulus wider than IN_W always yields "keep".
REQ-022 din=0 and din<M_tilde SHALL pass through unchanged.
REQ-023 din an exact multiple of M_tilde SHALL yield dout=0.
REQ-024 out_ready held low in DONE SHALL stall indefinitely with no loss of data.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, dout=0, R=0, k=0 and ovf=0.
REQ-026 Reset asserted in REDUCE or DONE SHALL abort the operation; no out_valid is produced for the aborted input.
REQ-027 The first cycle after reset release SHALL be able to accept in_valid.

Configuration
REQ-028 Without the macro: no range check; inputs ≥ M_tilde<<(SHIFT_MAX+1) produce an unspecified dout.
REQ-029 The ovf port and its logic are absent without the macro.
REQ-030 With UINT_MOD_REDUCER_OVF_CHECK_EN defined: at accept, SHALL set ovf=1 if din ≥ M_tilde<<(SHIFT_MAX+1). ovf is held with out_valid and cleared on handshake or reset; reduction still runs.

Structure
REQ-031 M_tilde, LEN_12M_TILDE, L3_CARRY and uint_fp_t SHALL come from PARAMS_BN254_d0.
REQ-032 A new localparam RED_STEPS=SHIFT_MAX+1 SHALL be added to that package.
REQ-033 One combinational sub-module, cond_sub_step, SHALL hold one compare/subtract step (inputs R and k; outputs next R and the borrow bit).
REQ-034 No other hierarchy SHALL be used; the FSM, counter and registers live in uint_mod_reducer.

Verification
REQ-035 din=0 -> dout=0 at exactly SHIFT_MAX+2 cycles after accept, ovf=0.
REQ-036 din=M_tilde-1 -> dout=M_tilde-1; din=M_tilde -> dout=0.
REQ-037 din=5*M_tilde+3 -> dout=3; din=(M_tilde<<SHIFT_MAX)+7 -> dout=7.
REQ-038 out_ready=0 for 10 cycles in DONE -> dout stable and in_ready=0 throughout; then out_ready=1 -> IDLE with in_ready=1 on the next cycle.
REQ-039 rst_n=0 for one cycle mid-REDUCE -> out_valid never rises for that input; a fresh din=2*M_tilde+1 then yields dout=1.
REQ-040 With the macro defined: din=M_tilde<<(SHIFT_MAX+1) -> ovf=1 together with out_valid; the next in-range input gives ovf=0.
